// File: rtl/vdp_host_pkg.sv
// rtl/vdp_host_pkg.sv - shared types and constants for the V9958 host port
// Contents:
//   cmd_op_t    : host command opcodes (values 5-7 are reserved)
//   bus_state_t : phases of one byte cycle on the CPU port
//   PORT_*      : mode values selecting the VDP port
//   CTRL_*      : control-port flag bits carried in the second byte
package vdp_host_pkg;

   typedef enum logic [2:0] {
      OP_RAW_WR   = 3'd0,
      OP_RAW_RD   = 3'd1,
      OP_REG_WR   = 3'd2,
      OP_VADDR_WR = 3'd3,
      OP_VADDR_RD = 3'd4
   } cmd_op_t;

   typedef enum logic [2:0] {
      BUS_IDLE,
      BUS_SETUP,
      BUS_STROBE,
      BUS_HOLD,
      BUS_RECOVER
   } bus_state_t;

   localparam logic [1:0] PORT_DATA = 2'd0;
   localparam logic [1:0] PORT_CTRL = 2'd1;
   localparam logic [1:0] PORT_PAL  = 2'd2;
   localparam logic [1:0] PORT_IND  = 2'd3;

   localparam logic [7:0] CTRL_REG   = 8'h80;
   localparam logic [7:0] CTRL_WADDR = 8'h40;

endpackage

// File: rtl/vdp_bus_cycle.sv
// rtl/vdp_bus_cycle.sv - single-byte CPU-port cycle engine (setup/strobe/hold/recover)
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : launch a byte; honoured in IDLE and on the last RECOVER cycle
//   start_port/wr/data    : port, direction (1 = write) and write byte for the launched cycle
//   finish                : high on the last RECOVER cycle of a byte
//   rd_data               : byte captured on the last STROBE cycle of a read, held otherwise
//   csw_n, csr_n          : write / read strobes, active low
//   mode, cd_o, cd_oe     : port select, bus drive data, bus output enable
//   cd_i                  : bus sample data
module vdp_bus_cycle
   import vdp_host_pkg::*;
#(
   parameter int SETUP_CYC    = 2,
   parameter int STROBE_CYC   = 6,
   parameter int HOLD_CYC     = 2,
   parameter int RECOVERY_CYC = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [1:0] start_port,
   input  logic       start_wr,
   input  logic [7:0] start_data,
   input  logic [7:0] cd_i,
   output logic       finish,
   output logic [7:0] rd_data,
   output logic       csw_n,
   output logic       csr_n,
   output logic [1:0] mode,
   output logic [7:0] cd_o,
   output logic       cd_oe
);

   localparam int MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int MAX_B   = (HOLD_CYC > RECOVERY_CYC) ? HOLD_CYC : RECOVERY_CYC;
   localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = $clog2(MAX_CYC) + 1;

   localparam logic [CW-1:0] L_SETUP   = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] L_STROBE  = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0] L_HOLD    = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] L_RECOVER = CW'(RECOVERY_CYC - 1);

   bus_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr_q, wr_d;
   logic [1:0]    mode_q, mode_d;
   logic [7:0]    cd_q, cd_d;
   logic [7:0]    rd_q, rd_d;
   logic          launch;
   logic          cnt_zero;

   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      mode_d  = mode_q;
      cd_d    = cd_q;
      rd_d    = rd_q;
      finish  = 1'b0;
      launch  = 1'b0;
      case (state_q)
         BUS_IDLE: launch = start;
         BUS_SETUP: begin
            if (cnt_zero) begin
               state_d = BUS_STROBE;
               cnt_d   = L_STROBE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         BUS_STROBE: begin
            if (cnt_zero) begin
               // sample as late as possible so the responder has had the whole pulse to drive
               if (!wr_q) rd_d = cd_i;
               state_d = BUS_HOLD;
               cnt_d   = L_HOLD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         BUS_HOLD: begin
            if (cnt_zero) begin
               state_d = BUS_RECOVER;
               cnt_d   = L_RECOVER;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         BUS_RECOVER: begin
            if (cnt_zero) begin
               finish  = 1'b1;
               state_d = BUS_IDLE;
               // chaining here lets a second byte follow without an extra IDLE cycle
               launch  = start;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = BUS_IDLE;
      endcase
      if (launch) begin
         state_d = BUS_SETUP;
         cnt_d   = L_SETUP;
         wr_d    = start_wr;
         mode_d  = start_port;
         cd_d    = start_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= BUS_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         mode_q  <= 2'd0;
         cd_q    <= 8'h00;
         rd_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         mode_q  <= mode_d;
         cd_q    <= cd_d;
         rd_q    <= rd_d;
      end
   end

   // strobes and enable decode straight from flops so reset releases the bus without a clock
   assign csw_n   = ~((state_q == BUS_STROBE) & wr_q);
   assign csr_n   = ~((state_q == BUS_STROBE) & ~wr_q);
   assign cd_oe   = wr_q & ((state_q == BUS_SETUP) | (state_q == BUS_STROBE) | (state_q == BUS_HOLD));
   assign mode    = mode_q;
   assign cd_o    = cd_q;
   assign rd_data = rd_q;

endmodule

// File: rtl/vdp_host_port.sv
// rtl/vdp_host_port.sv - V9958 CPU-port host initiator with command expansion
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake, ready only while idle
//   cmd_op, cmd_port, cmd_data : opcode, raw port, payload (sampled at accept only)
//   done, rsp_data           : completion pulse, last read byte
//   csw_n, csr_n, mode       : strobes and port select to the VDP
//   cd_o, cd_oe, cd_i        : bus drive data, drive enable, sample data
module vdp_host_port
   import vdp_host_pkg::*;
#(
   parameter int SETUP_CYC    = 2,
   parameter int STROBE_CYC   = 6,
   parameter int HOLD_CYC     = 2,
   parameter int RECOVERY_CYC = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [1:0]  cmd_port,
   input  logic [13:0] cmd_data,
   output logic        done,
   output logic [7:0]  rsp_data,
   output logic        csw_n,
   output logic        csr_n,
   output logic [1:0]  mode,
   output logic [7:0]  cd_o,
   output logic        cd_oe,
   input  logic [7:0]  cd_i
);

   logic       busy_q, busy_d;
   logic       bi_q, bi_d;
   logic [1:0] nb_q, nb_d;
   logic [7:0] b1_q, b1_d;
   logic       done_q, done_d;

   logic       dec_reserved;
   logic [1:0] dec_port;
   logic       dec_wr;
   logic [7:0] dec_b0, dec_b1;
   logic [1:0] dec_nb;

   logic       eng_start, eng_wr, eng_finish;
   logic [1:0] eng_port;
   logic [7:0] eng_data;

   logic       accept;

   assign cmd_ready = ~busy_q;
   assign accept    = cmd_valid & ~busy_q;

   // expand the command into first byte, optional second control-port byte
   always_comb begin
      dec_reserved = 1'b0;
      dec_port     = PORT_CTRL;
      dec_wr       = 1'b1;
      dec_b0       = cmd_data[7:0];
      dec_b1       = 8'h00;
      dec_nb       = 2'd2;
      case (cmd_op)
         OP_RAW_WR: begin
            dec_port = cmd_port;
            dec_nb   = 2'd1;
         end
         OP_RAW_RD: begin
            dec_port = cmd_port;
            dec_wr   = 1'b0;
            dec_b0   = 8'h00;
            dec_nb   = 2'd1;
         end
         OP_REG_WR:   dec_b1 = CTRL_REG | {2'b00, cmd_data[13:8]};
         OP_VADDR_WR: dec_b1 = CTRL_WADDR | {2'b00, cmd_data[13:8]};
         OP_VADDR_RD: dec_b1 = {2'b00, cmd_data[13:8]};
         default: begin
            dec_reserved = 1'b1;
            dec_nb       = 2'd1;
         end
      endcase
   end

   always_comb begin
      busy_d    = busy_q;
      bi_d      = bi_q;
      nb_d      = nb_q;
      b1_d      = b1_q;
      done_d    = 1'b0;
      eng_start = 1'b0;
      eng_port  = dec_port;
      eng_wr    = dec_wr;
      eng_data  = dec_b0;
      if (accept) begin
         if (dec_reserved) begin
            done_d = 1'b1;
         end else begin
            busy_d    = 1'b1;
            bi_d      = 1'b0;
            nb_d      = dec_nb;
            b1_d      = dec_b1;
            eng_start = 1'b1;
         end
      end else if (busy_q && eng_finish) begin
         if ({1'b0, bi_q} < (nb_q - 2'd1)) begin
            bi_d      = 1'b1;
            eng_start = 1'b1;
            eng_port  = PORT_CTRL;
            eng_wr    = 1'b1;
            eng_data  = b1_q;
         end else begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= 1'b0;
         bi_q   <= 1'b0;
         nb_q   <= 2'd1;
         b1_q   <= 8'h00;
         done_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         bi_q   <= bi_d;
         nb_q   <= nb_d;
         b1_q   <= b1_d;
         done_q <= done_d;
      end
   end

   assign done = done_q;

   vdp_bus_cycle #(
      .SETUP_CYC    (SETUP_CYC),
      .STROBE_CYC   (STROBE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .RECOVERY_CYC (RECOVERY_CYC)
   ) u_bus_cycle (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (eng_start),
      .start_port (eng_port),
      .start_wr   (eng_wr),
      .start_data (eng_data),
      .cd_i       (cd_i),
      .finish     (eng_finish),
      .rd_data    (rsp_data),
      .csw_n      (csw_n),
      .csr_n      (csr_n),
      .mode       (mode),
      .cd_o       (cd_o),
      .cd_oe      (cd_oe)
   );

endmodule

// File: tb/tb_vdp_host_port.sv
// tb/tb_vdp_host_port.sv - scoreboard bench for vdp_host_port
module tb_vdp_host_port;

   localparam int SETUP_CYC    = 2;
   localparam int STROBE_CYC   = 6;
   localparam int HOLD_CYC     = 2;
   localparam int RECOVERY_CYC = 4;
   localparam int T = SETUP_CYC + STROBE_CYC + HOLD_CYC + RECOVERY_CYC;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [1:0]  cmd_port;
   logic [13:0] cmd_data;
   logic        done;
   logic [7:0]  rsp_data;
   logic        csw_n;
   logic        csr_n;
   logic [1:0]  mode;
   logic [7:0]  cd_o;
   logic        cd_oe;
   logic [7:0]  cd_i;

   typedef struct {
      logic [1:0] port;
      logic       wr;
      logic [7:0] val;
      int         fall;
   } exp_byte_t;

   typedef struct {
      int         cyc;
      logic [7:0] rsp;
   } exp_done_t;

   exp_byte_t bq[$];
   exp_done_t dq[$];

   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   logic [7:0] last_rsp = 8'h00;

   vdp_host_port #(
      .SETUP_CYC    (SETUP_CYC),
      .STROBE_CYC   (STROBE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .RECOVERY_CYC (RECOVERY_CYC)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_port  (cmd_port),
      .cmd_data  (cmd_data),
      .done      (done),
      .rsp_data  (rsp_data),
      .csw_n     (csw_n),
      .csr_n     (csr_n),
      .mode      (mode),
      .cd_o      (cd_o),
      .cd_oe     (cd_oe),
      .cd_i      (cd_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push_byte(input logic [1:0] port, input logic wr, input logic [7:0] val,
                                     input int fall);
      exp_byte_t e;
      e.port = port;
      e.wr   = wr;
      e.val  = val;
      e.fall = fall;
      bq.push_back(e);
   endfunction

   // Reference model: list the bus bytes each command must produce, straight from the opcode table.
   task automatic issue(input logic [2:0] op, input logic [1:0] port, input logic [13:0] data,
                        input logic [7:0] rdv, output int acc);
      int        n;
      int        f0;
      exp_done_t d;
      cmd_op    = op;
      cmd_port  = port;
      cmd_data  = data;
      cmd_valid = 1'b1;
      acc       = -1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) begin
         check("accept_timeout", 64'(cmd_ready), 64'd1);
         cmd_valid = 1'b0;
         return;
      end
      n  = 0;
      f0 = acc + SETUP_CYC + 1;
      case (op)
         3'd0: begin push_byte(port, 1'b1, data[7:0], f0); n = 1; end
         3'd1: begin push_byte(port, 1'b0, 8'h00, f0); n = 1; end
         3'd2: begin
            push_byte(2'd1, 1'b1, data[7:0], f0);
            push_byte(2'd1, 1'b1, 8'h80 | {2'b00, data[13:8]}, f0 + T);
            n = 2;
         end
         3'd3: begin
            push_byte(2'd1, 1'b1, data[7:0], f0);
            push_byte(2'd1, 1'b1, 8'h40 | {2'b00, data[13:8]}, f0 + T);
            n = 2;
         end
         3'd4: begin
            push_byte(2'd1, 1'b1, data[7:0], f0);
            push_byte(2'd1, 1'b1, {2'b00, data[13:8]} & 8'h3F, f0 + T);
            n = 2;
         end
         default: n = 0;
      endcase
      if (op == 3'd1) begin
         last_rsp = rdv;
         cd_i     = rdv;
      end
      d.cyc = acc + n * T + 1;
      d.rsp = last_rsp;
      dq.push_back(d);
      @(posedge clk);
      #1;
      // later changes on cmd_* must have no effect
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom);
      cmd_port  = 2'($urandom);
      cmd_data  = 14'($urandom);
   endtask

   // Monitor: pops expectations whenever the bus or done shows activity.
   initial begin : monitor
      exp_byte_t cur;
      exp_done_t de;
      int        cnt;
      bit        active;
      bit        oe_ok;
      cur    = '{port: 2'd0, wr: 1'b0, val: 8'h00, fall: 0};
      active = 1'b0;
      cnt    = 0;
      oe_ok  = 1'b1;
      forever begin
         @(negedge clk);
         if (reset_n !== 1'b1) begin
            active = 1'b0;
         end else begin
            if (active) begin
               if (!csw_n || !csr_n) begin
                  cnt++;
                  if (cd_oe !== cur.wr) oe_ok = 1'b0;
               end else begin
                  check("strobe_rise",
                        64'({8'(cnt), oe_ok, mode, cur.wr ? cd_o : 8'h00, cd_oe}),
                        64'({8'(STROBE_CYC), 1'b1, cur.port, cur.wr ? cur.val : 8'h00, cur.wr}));
                  active = 1'b0;
               end
            end else if (!csw_n || !csr_n) begin
               if (bq.size() == 0) begin
                  check("unexpected_strobe", 64'(bq.size()), 64'd1);
               end else begin
                  cur = bq.pop_front();
                  check("strobe_fall",
                        64'({~csw_n, ~csr_n, mode, cur.wr ? cd_o : 8'h00, cd_oe, cyc}),
                        64'({cur.wr, ~cur.wr, cur.port, cur.wr ? cur.val : 8'h00, cur.wr, cur.fall}));
                  active = 1'b1;
                  cnt    = 1;
                  oe_ok  = (cd_oe === cur.wr);
               end
            end
            if (done === 1'b1) begin
               if (dq.size() == 0) begin
                  check("unexpected_done", 64'(dq.size()), 64'd1);
               end else begin
                  de = dq.pop_front();
                  check("done", 64'({cyc, rsp_data, cmd_ready}), 64'({de.cyc, de.rsp, 1'b1}));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int         a1, a2, a;
      logic [2:0] op;
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_port  = 2'd0;
      cmd_data  = 14'd0;
      cd_i      = 8'h00;
      #23;
      check("reset_outputs",
            64'({csw_n, csr_n, cd_oe, cd_o, mode, done, rsp_data, cmd_ready}),
            64'({1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 1'b1}));
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // REG_WR reg 7 = 0xF4
      issue(3'd2, 2'd0, {6'd7, 8'hF4}, 8'h00, a);

      // VADDR_WR 0x1234 then RAW_WR port 0 0xAA back-to-back
      issue(3'd3, 2'd3, 14'h1234, 8'h00, a1);
      issue(3'd0, 2'd0, {6'h3F, 8'hAA}, 8'h00, a2);
      check("b2b_accept", 64'(a2), 64'(a1 + 2 * T + 1));

      // RAW_RD port 1 returning 0x9F
      issue(3'd1, 2'd1, 14'h0000, 8'h9F, a);

      // reserved op
      issue(3'd6, 2'd2, 14'h3FFF, 8'h00, a);

      // reset during the second strobe of a REG_WR
      issue(3'd2, 2'd0, {6'd12, 8'h5A}, 8'h00, a);
      while (cyc < a + T + SETUP_CYC + 3) @(negedge clk);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("reset_mid_release", 64'({csw_n, csr_n, cd_oe, done, cmd_ready}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b1}));
      dq.delete();
      last_rsp = 8'h00;
      check("reset_mid_bytes", 64'(bq.size()), 64'd0);
      bq.delete();
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_reset_idle", 64'({done, csw_n, csr_n, cd_oe, cmd_ready, rsp_data}),
            64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00}));
      issue(3'd4, 2'd0, 14'h2ABC, 8'h00, a);

      // randomized traffic
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 7));
         issue(op, 2'($urandom), 14'($urandom), 8'($urandom), a);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      for (int k = 0; k < 500 && dq.size() != 0; k++) @(posedge clk);
      repeat (2) @(posedge clk);
      check("drain_done", 64'(dq.size()), 64'd0);
      check("drain_bytes", 64'(bq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
